// File: rtl/run_monitor_pkg.sv
// Shared definitions for the run-control monitor: state encoding, default PC
// width and an index-width helper.
package run_monitor_pkg;

    localparam int ADDR_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } state_e;

    // Index width for an n-entry table, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/run_monitor_halt_match_bank.sv
// Combinational bank of halt-address comparators with a lowest-index-wins
// priority encoder.
module halt_match_bank
    import run_monitor_pkg::*;
#(
    parameter int ADDR_W = ADDR_SIZE,
    parameter int N_HALT = 4,
    parameter int IDX_W  = clog2_min1(N_HALT)
) (
    input  logic [ADDR_W-1:0]        pc,
    input  logic                     pc_valid,
    input  logic [N_HALT*ADDR_W-1:0] halt_addr,
    input  logic [N_HALT-1:0]        halt_en,
    output logic                     hit,
    output logic [IDX_W-1:0]         idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < N_HALT; i++) begin
            if (!hit && pc_valid && halt_en[i] &&
                (halt_addr[i*ADDR_W +: ADDR_W] == pc)) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Run-control monitor: counts cycles and retired PCs during a run and ends it
// on a halt-address match, a PC self-loop stall, or a cycle-budget timeout.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int ADDR_W    = ADDR_SIZE,
    parameter int N_HALT    = 4,
    parameter int CNT_W     = 32,
    parameter int TIMEOUT   = 100000,
    parameter int STALL_LIM = 16
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            arm,
    input  logic [ADDR_W-1:0]               pc,
    input  logic                            pc_valid,
    input  logic [N_HALT*ADDR_W-1:0]        halt_addr,
    input  logic [N_HALT-1:0]               halt_en,
    output logic                            running,
    output logic                            done,
    output logic                            fault,
    output logic [clog2_min1(N_HALT)-1:0]   halt_idx,
    output logic                            timed_out,
    output logic                            stalled,
    output logic [CNT_W-1:0]                cycle_count,
    output logic [CNT_W-1:0]                retire_count
);

    localparam int IDX_W   = clog2_min1(N_HALT);
    localparam int STALL_W = clog2_min1(STALL_LIM + 1);

    localparam logic [CNT_W-1:0]   CNT_MAX      = '1;
    localparam logic [63:0]        TIMEOUT_LAST = (TIMEOUT > 0) ? 64'(TIMEOUT - 1) : '0;
    localparam logic [STALL_W-1:0] STALL_LAST   = (STALL_LIM > 0) ? STALL_W'(STALL_LIM - 1) : '0;

    state_e state_q, state_d;

    logic [CNT_W-1:0]   cycle_count_q,  cycle_count_d;
    logic [CNT_W-1:0]   retire_count_q, retire_count_d;
    logic [STALL_W-1:0] stall_cnt_q,    stall_cnt_d;
    logic [ADDR_W-1:0]  prev_pc_q,      prev_pc_d;
    logic [IDX_W-1:0]   halt_idx_q,     halt_idx_d;
    logic               timed_out_q,    timed_out_d;
    logic               stalled_q,      stalled_d;

    logic             bank_hit;
    logic [IDX_W-1:0] bank_idx;
    logic             in_run;
    logic             start;
    logic             pc_repeat;
    logic             stall_trip;
    logic             timeout_trip;

    halt_match_bank #(
        .ADDR_W (ADDR_W),
        .N_HALT (N_HALT),
        .IDX_W  (IDX_W)
    ) u_halt_match_bank (
        .pc        (pc),
        .pc_valid  (pc_valid),
        .halt_addr (halt_addr),
        .halt_en   (halt_en),
        .hit       (bank_hit),
        .idx       (bank_idx)
    );

    // Trip decodes look at the pre-increment counters of the current cycle.
    always_comb begin
        in_run       = (state_q == RUN);
        start        = !in_run && arm;
        pc_repeat    = pc_valid && (pc == prev_pc_q);
        stall_trip   = (STALL_LIM > 0) && in_run && pc_repeat &&
                       (stall_cnt_q == STALL_LAST);
        timeout_trip = (TIMEOUT > 0) && in_run &&
                       (64'(cycle_count_q) == TIMEOUT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, HALTED, FAULT: begin
                if (arm) state_d = RUN;
            end
            RUN: begin
                if (bank_hit)                        state_d = HALTED;
                else if (stall_trip || timeout_trip) state_d = FAULT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        running = (state_q == RUN);
        done    = (state_q == HALTED);
        fault   = (state_q == FAULT);
    end

    always_comb begin
        cycle_count_d  = cycle_count_q;
        retire_count_d = retire_count_q;
        stall_cnt_d    = stall_cnt_q;
        prev_pc_d      = prev_pc_q;
        halt_idx_d     = halt_idx_q;
        timed_out_d    = timed_out_q;
        stalled_d      = stalled_q;

        if (start) begin
            cycle_count_d  = '0;
            retire_count_d = '0;
            stall_cnt_d    = '0;
            prev_pc_d      = '0;
            halt_idx_d     = '0;
            timed_out_d    = 1'b0;
            stalled_d      = 1'b0;
        end else if (in_run) begin
            if (cycle_count_q != CNT_MAX) cycle_count_d = cycle_count_q + 1'b1;
            if (pc_valid) begin
                if (retire_count_q != CNT_MAX) retire_count_d = retire_count_q + 1'b1;
                prev_pc_d = pc;
                if (STALL_LIM > 0) begin
                    stall_cnt_d = pc_repeat ? stall_cnt_q + 1'b1 : '0;
                end
            end
            // Only one cause flag is recorded per ended run.
            if (bank_hit)          halt_idx_d  = bank_idx;
            else if (stall_trip)   stalled_d   = 1'b1;
            else if (timeout_trip) timed_out_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cycle_count_q  <= '0;
            retire_count_q <= '0;
            stall_cnt_q    <= '0;
            prev_pc_q      <= '0;
            halt_idx_q     <= '0;
            timed_out_q    <= 1'b0;
            stalled_q      <= 1'b0;
        end else begin
            cycle_count_q  <= cycle_count_d;
            retire_count_q <= retire_count_d;
            stall_cnt_q    <= stall_cnt_d;
            prev_pc_q      <= prev_pc_d;
            halt_idx_q     <= halt_idx_d;
            timed_out_q    <= timed_out_d;
            stalled_q      <= stalled_d;
        end
    end

    always_comb begin
        halt_idx     = halt_idx_q;
        timed_out    = timed_out_q;
        stalled      = stalled_q;
        cycle_count  = cycle_count_q;
        retire_count = retire_count_q;
    end

endmodule

// File: doc/run_monitor.md
# run_monitor

Parametrised run-control monitor for the single-cycle core's simulation and FPGA bring-up environment. Samples the core's program counter every cycle, counts cycles and retired PCs, and ends a run on a match against any of N programmable halt addresses. Also ends a run on a cycle-budget timeout or a PC-stall (self-loop) condition. Replaces hard-coded single-address halt checks in benches with a reusable block that reports which halt fired and why a run ended.

## Interface
Parameters:
- ADDR_W, 32 (`ADDR_SIZE`), PC width
- N_HALT, 4, number of halt-address comparators
- CNT_W, 32, width of cycle and retire counters
- TIMEOUT, 100000, cycle budget per run; 0 disables
- STALL_LIM, 16, consecutive identical valid PCs that flag a stall; 0 disables

Ports:
- clk  in  1  clock; all state changes on rising edge
- rstn  in  1  synchronous active-low reset, sampled on rising clk
- arm  in  1  start/restart pulse
- pc  in  ADDR_W  core PC
- pc_valid  in  1  pc holds a committed instruction this cycle
- halt_addr  in  N_HALT*ADDR_W  flattened halt addresses; entry i at [i*ADDR_W +: ADDR_W]
- halt_en  in  N_HALT  per-entry enable
- running  out  1  state is RUN
- done  out  1  run ended by halt match (sticky)
- fault  out  1  run ended by timeout or stall (sticky)
- halt_idx  out  $clog2(N_HALT) (min 1)  index of matching entry
- timed_out  out  1  fault cause: timeout
- stalled  out  1  fault cause: stall
- cycle_count  out  CNT_W  cycles spent in RUN
- retire_count  out  CNT_W  valid PCs seen in RUN

## Operation
- States: IDLE, RUN, HALTED, FAULT.
- IDLE: arm -> RUN.
- HALTED/FAULT: arm -> RUN (restart).
- On entry to RUN: clear counters, stall counter, prev-PC, done, fault, cause flags, halt_idx.
- RUN, per cycle: cycle_count += 1; if pc_valid, retire_count += 1. Both counters saturate at all-ones, never wrap.
- Halt match: pc_valid and pc == halt_addr[i] and halt_en[i]. Lowest i wins. -> HALTED; done=1; halt_idx=i.
- Stall (STALL_LIM>0):
  - stall_cnt increments when pc_valid and pc == prev_pc.
  - Resets to 0 on pc_valid with a different PC.
  - Holds when pc_valid=0.
  - Reaching STALL_LIM -> FAULT with stalled=1.
- Timeout (TIMEOUT>0): cycle_count == TIMEOUT-1 while in RUN -> FAULT with timed_out=1.
- Priority in one cycle: halt match > stall > timeout. Exactly one cause flag set per ended run.
- arm in RUN is ignored; it does not restart a run in progress.
- prev_pc updates on every pc_valid in RUN.
- Reset: state IDLE. All outputs 0: running, done, fault, halt_idx, timed_out, stalled, cycle_count, retire_count.
- rstn low mid-run aborts to IDLE on that edge. Counters are not preserved.

## Timing
- Registered outputs. A match or trip on sample cycle k shows on done/fault at edge k+1; running drops at the same edge.
- The terminating cycle is counted: cycle_count and retire_count include cycle k.
- arm sampled at edge t: running=1 after t; the first counted cycle is t+1.
- Timeout run: fault rises exactly TIMEOUT cycles after running rises.
- Halt matched on an already-stalled self-loop PC reports done, not fault.
- halt_en/halt_addr are sampled combinationally every cycle; changing them mid-run takes effect the same cycle.

## Structure
- Shared package/defines header (alongside `xgriscv_defines.v`): state encoding localparams (IDLE=2'd0, RUN=2'd1, HALTED=2'd2, FAULT=2'd3) and the ADDR_SIZE default.
- Sub-module `halt_match_bank`: combinational N_HALT comparator bank plus lowest-index priority encoder. Outputs hit and idx.
- Top holds the FSM, counters, stall tracker and output registers.

## Test plan
- Reset during RUN with cycle_count=57 -> next edge: state IDLE, all outputs 0.
- N_HALT=4; halt_addr[2]=0x80000078 and halt_addr[3]=0x80000078, both enabled; arm; PC steps 0x80000000 by 4 -> done=1, halt_idx=2, retire_count=31, fault=0.
- STALL_LIM=16; PC sticks at 0x80000040 with pc_valid=1 -> stalled=1 one cycle after the 16th repeat.
  - Repeat with pc_valid toggling 0/1 -> trip delayed accordingly.
  - Repeat with 0x80000040 halt-enabled -> done instead of fault.
- TIMEOUT=100; no halt enabled; stall disabled -> fault=1 and timed_out=1 exactly 100 cycles after running; cycle_count=100.
- CNT_W=4; TIMEOUT=0 -> cycle_count saturates at 15 and holds. arm mid-run is ignored. arm after HALTED clears done and counters and restarts.
